pipe_hazard_ctrl: RTL and testbench

Parametrised, stateful successor to the Y86 pipeline stall/bubble controller, sitting between the five pipeline registers (F, D, E, M, W) and the stage datapaths. It resolves load/use, `ret` and jump-misprediction hazards with defined priorities. It also handles exceptions from the memory and write-back stages, stalls the whole pipe while data memory is slow, and latches a terminal halt state. Optional performance counters record stall and bubble cycles.

---
 rtl/pipe_hazard_ctrl_if.sv | 60 ++++++
 rtl/pipe_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundles the hazard controller's pipeline-side signals.
//   master : the pipeline/datapath side. It drives the stage icodes, register
//            IDs, status codes and memory handshake. It receives the
//            stall/bubble controls, status flags and counters.
//   slave  : the hazard controller itself (mirror of master).
// Parameters:
//   REG_W  register-ID width
//   CNT_W  performance counter width
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 32
);
    // Pipeline -> controller
    logic [3:0]       D_icode;
    logic [3:0]       E_icode;
    logic [3:0]       M_icode;
    logic [REG_W-1:0] d_srcA;
    logic [REG_W-1:0] d_srcB;
    logic [REG_W-1:0] E_dstM;
    logic             e_cnd;
    logic [3:0]       m_stat;
    logic [3:0]       W_stat;
    logic             mem_req;
    logic             mem_ready;

    // Controller -> pipeline
    logic             F_stall;
    logic             D_stall;
    logic             E_stall;
    logic             M_stall;
    logic             W_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_bubble;
    logic             cc_block;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] bubble_cycles;

    modport master (
        output D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, e_cnd,
               m_stat, W_stat, mem_req, mem_ready,
        input  F_stall, D_stall, E_stall, M_stall, W_stall,
               D_bubble, E_bubble, M_bubble, W_bubble, cc_block,
               halted, mem_timeout, stall_cycles, bubble_cycles
    );

    modport slave (
        input  D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, e_cnd,
               m_stat, W_stat, mem_req, mem_ready,
        output F_stall, D_stall, E_stall, M_stall, W_stall,
               D_bubble, E_bubble, M_bubble, W_bubble, cc_block,
               halted, mem_timeout, stall_cycles, bubble_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall/bubble controller for a five-stage Y86 pipeline (F, D, E, M, W).
//
// Hazards resolved:
//   - load/use
//   - ret
//   - jump misprediction
//   - memory/write-back exceptions
//   - slow data memory (whole-pipe stall)
// A write-back exception or a memory wait timeout puts the controller into
// a terminal HALT state, which only reset leaves.
//
// Ports:
//   clk    pipeline clock
//   rst_n  asynchronous active-low reset
//   bus    pipe_hazard_ctrl_if.slave, carrying:
//            inputs   D/E/M icodes, d_srcA/d_srcB, E_dstM, e_cnd,
//                     m_stat, W_stat, mem_req, mem_ready
//            outputs  F..W stalls, D..W bubbles, cc_block, halted,
//                     mem_timeout, stall_cycles, bubble_cycles
//
// Parameters: REG_W, RNONE, MAX_WAIT (1..255), CNT_W.
//
// Optional feature: define PIPE_HAZARD_PERF_CNT_EN to build the saturating
// stall/bubble cycle counters. Without it, both counter outputs read 0.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int               REG_W    = 4,
    parameter logic [REG_W-1:0] RNONE    = {REG_W{1'b1}},
    parameter int               MAX_WAIT = 15,
    parameter int               CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam logic [3:0] IC_MRMOVQ = 4'h5;
    localparam logic [3:0] IC_JXX    = 4'h7;
    localparam logic [3:0] IC_RET    = 4'h9;
    localparam logic [3:0] IC_POPQ   = 4'hB;
    localparam logic [3:0] STAT_AOK  = 4'h1;
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    // -----------------------------------------------------------------------
    // Hazard terms
    // -----------------------------------------------------------------------
    logic lu, ret_h, mis, mw, mx, wx;

    always_comb begin
        lu    = ((bus.E_icode == IC_MRMOVQ) || (bus.E_icode == IC_POPQ))
                && (bus.E_dstM != RNONE)
                && ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
        ret_h = (bus.D_icode == IC_RET) || (bus.E_icode == IC_RET)
                || (bus.M_icode == IC_RET);
        mis   = (bus.E_icode == IC_JXX) && !bus.e_cnd;
        mw    = bus.mem_req && !bus.mem_ready;
        mx    = (bus.m_stat != STAT_AOK);
        wx    = (bus.W_stat != STAT_AOK);
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // wait_cnt_q holds the number of wait cycles already completed. The
    // timeout fires on the edge that completes the MAX_WAIT-th consecutive
    // wait cycle, so the current wait cycle is counted before the compare.
    // A MAX_WAIT of 1 times out straight from RUN.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (wx) begin
                    state_d = ST_HALT;
                end else if (mw) begin
                    if (MAX_WAIT_C == 8'd1) begin
                        state_d   = ST_HALT;
                        timeout_d = 1'b1;
                    end else begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = 8'd1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (wx) begin
                    state_d = ST_HALT;
                end else if (bus.mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == (MAX_WAIT_C - 8'd1)) begin
                    state_d   = ST_HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control outputs, in priority order: reset, HALT, memory wait, hazards.
    // Holding every register while reset is low keeps the pipe quiet until
    // the controller is out of reset.
    // -----------------------------------------------------------------------
    logic f_stall, d_stall, e_stall, m_stall, w_stall;
    logic d_bubble, e_bubble, m_bubble, w_bubble, cc_blk;

    always_comb begin
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        e_stall  = 1'b0;
        m_stall  = 1'b0;
        w_stall  = 1'b0;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        m_bubble = 1'b0;
        w_bubble = 1'b0;
        cc_blk   = 1'b0;
        if (rst_n) begin
            if (state_q == ST_HALT) begin
                f_stall = 1'b1;
                d_stall = 1'b1;
                e_stall = 1'b1;
                m_stall = 1'b1;
                w_stall = 1'b1;
                cc_blk  = 1'b1;
            end else if (mw) begin
                // Freeze F..M. W drains into a nop so nothing retires twice.
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                e_stall  = 1'b1;
                m_stall  = 1'b1;
                w_bubble = 1'b1;
            end else begin
                f_stall  = lu | ret_h;
                d_stall  = lu;
                // A load/use stall holds D, so a ret there must not also be
                // squashed this cycle; it is handled once the load moves on.
                d_bubble = mis | (ret_h & !lu);
                e_bubble = mis | lu;
                m_bubble = mx | wx;
                w_stall  = wx;
                cc_blk   = mx | wx;
            end
        end
    end

    assign bus.F_stall     = f_stall;
    assign bus.D_stall     = d_stall;
    assign bus.E_stall     = e_stall;
    assign bus.M_stall     = m_stall;
    assign bus.W_stall     = w_stall;
    assign bus.D_bubble    = d_bubble;
    assign bus.E_bubble    = e_bubble;
    assign bus.M_bubble    = m_bubble;
    assign bus.W_bubble    = w_bubble;
    assign bus.cc_block    = cc_blk;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.mem_timeout = timeout_q;

    // -----------------------------------------------------------------------
    // Performance counters (saturating, frozen in HALT)
    // -----------------------------------------------------------------------
`ifdef PIPE_HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else if (state_q != ST_HALT) begin
            if (f_stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if ((e_bubble || w_bubble) && (bubble_cnt_q != CNT_MAX)) begin
                bubble_cnt_q <= bubble_cnt_q + CNT_ONE;
            end
        end
    end

    assign bus.stall_cycles  = stall_cnt_q;
    assign bus.bubble_cycles = bubble_cnt_q;
`else
    assign bus.stall_cycles  = '0;
    assign bus.bubble_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. The main instance (MAX_WAIT=4,
// CNT_W=32) is driven directly. A second instance (CNT_W=3) sees the same
// inputs and shows counter saturation. Control outputs are packed as
// {F,D,E,M,W stall, D,E,M,W bubble, cc_block} for compact expectations.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;

    pipe_hazard_ctrl_if #(.REG_W(4), .CNT_W(32)) bus_a ();
    pipe_hazard_ctrl_if #(.REG_W(4), .CNT_W(3))  bus_b ();

    pipe_hazard_ctrl #(.REG_W(4), .MAX_WAIT(4), .CNT_W(32)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    pipe_hazard_ctrl #(.REG_W(4), .MAX_WAIT(15), .CNT_W(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    assign bus_b.D_icode   = bus_a.D_icode;
    assign bus_b.E_icode   = bus_a.E_icode;
    assign bus_b.M_icode   = bus_a.M_icode;
    assign bus_b.d_srcA    = bus_a.d_srcA;
    assign bus_b.d_srcB    = bus_a.d_srcB;
    assign bus_b.E_dstM    = bus_a.E_dstM;
    assign bus_b.e_cnd     = bus_a.e_cnd;
    assign bus_b.m_stat    = bus_a.m_stat;
    assign bus_b.W_stat    = bus_a.W_stat;
    assign bus_b.mem_req   = bus_a.mem_req;
    assign bus_b.mem_ready = bus_a.mem_ready;

    logic [9:0] vec_a;
    assign vec_a = {bus_a.F_stall, bus_a.D_stall, bus_a.E_stall, bus_a.M_stall,
                    bus_a.W_stall, bus_a.D_bubble, bus_a.E_bubble,
                    bus_a.M_bubble, bus_a.W_bubble, bus_a.cc_block};

    localparam logic [9:0] V_NONE  = 10'b0000000000;
    localparam logic [9:0] V_LU    = 10'b1100001000;
    localparam logic [9:0] V_MIS   = 10'b0000011000;
    localparam logic [9:0] V_MISR  = 10'b1000011000;
    localparam logic [9:0] V_RETM  = 10'b1000010000;
    localparam logic [9:0] V_MX    = 10'b0000000101;
    localparam logic [9:0] V_WX    = 10'b0000100101;
    localparam logic [9:0] V_MW    = 10'b1111000010;
    localparam logic [9:0] V_HALT  = 10'b1111100001;

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        if (obs === exp)
            $display("[%0t] %s: observed 0x%0h expected 0x%0h ok", $time, tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus_a.D_icode   = 4'h1;
        bus_a.E_icode   = 4'h1;
        bus_a.M_icode   = 4'h1;
        bus_a.d_srcA    = 4'hF;
        bus_a.d_srcB    = 4'hF;
        bus_a.E_dstM    = 4'hF;
        bus_a.e_cnd     = 1'b1;
        bus_a.m_stat    = 4'h1;
        bus_a.W_stat    = 4'h1;
        bus_a.mem_req   = 1'b0;
        bus_a.mem_ready = 1'b0;
    endtask

    initial begin
        // ---- reset, with a load/use pattern applied to show the forcing ----
        rst_n = 1'b0;
        set_idle();
        bus_a.E_icode = 4'h5;
        bus_a.E_dstM  = 4'h3;
        bus_a.d_srcA  = 4'h3;
        tick();
        tick();
        chk("reset_outputs", vec_a, V_NONE);
        chk("reset_halted", bus_a.halted, 1'b0);
        chk("reset_timeout", bus_a.mem_timeout, 1'b0);
        chk("reset_stall_cnt", bus_a.stall_cycles, 0);
        chk("reset_bubble_cnt", bus_a.bubble_cycles, 0);
        rst_n = 1'b1;

        set_idle();
        #1 chk("idle", vec_a, V_NONE);

        // ---- load/use held for 5 edges ----
        bus_a.E_icode = 4'h5;
        bus_a.E_dstM  = 4'h3;
        bus_a.d_srcA  = 4'h3;
        #1 chk("load_use", vec_a, V_LU);
        repeat (5) tick();
        bus_a.E_dstM = 4'hF;
        bus_a.d_srcA = 4'hF;
        #1 chk("load_use_rnone", vec_a, V_NONE);

        // ---- mispredict held for 2 edges ----
        set_idle();
        bus_a.E_icode = 4'h7;
        bus_a.e_cnd   = 1'b0;
        #1 chk("mispredict", vec_a, V_MIS);
        repeat (2) tick();
        chk("cnt_stall_a_5", bus_a.stall_cycles, CNT_ON ? 5 : 0);
        chk("cnt_bubble_a_7", bus_a.bubble_cycles, CNT_ON ? 7 : 0);
        chk("cnt_stall_b_5", bus_b.stall_cycles, CNT_ON ? 5 : 0);

        // ---- combinational combinations, all between two edges ----
        set_idle();
        bus_a.E_icode = 4'h7;
        bus_a.e_cnd   = 1'b0;
        bus_a.D_icode = 4'h9;
        #1 chk("mis_and_ret_d", vec_a, V_MISR);
        set_idle();
        bus_a.M_icode = 4'h9;
        #1 chk("ret_in_m", vec_a, V_RETM);
        set_idle();
        bus_a.E_icode = 4'h5;
        bus_a.E_dstM  = 4'h3;
        bus_a.d_srcB  = 4'h3;
        bus_a.D_icode = 4'h9;
        #1 chk("lu_and_ret_d", vec_a, V_LU);
        set_idle();
        bus_a.m_stat = 4'h3;
        #1 chk("m_exception", vec_a, V_MX);
        set_idle();
        bus_a.E_icode = 4'h7;
        #1 chk("jxx_taken", vec_a, V_NONE);
        set_idle();
        tick();

        // ---- memory wait of 3 cycles ----
        bus_a.mem_req = 1'b1;
        #1 chk("mem_wait_c1", vec_a, V_MW);
        tick();
        chk("mem_wait_c2", vec_a, V_MW);
        tick();
        chk("mem_wait_c3", vec_a, V_MW);
        tick();
        bus_a.mem_ready = 1'b1;
        #1 chk("mem_ready", vec_a, V_NONE);
        tick();
        bus_a.mem_req   = 1'b0;
        bus_a.mem_ready = 1'b0;
        #1 chk("mem_wait_halted", bus_a.halted, 1'b0);
        chk("mem_wait_timeout", bus_a.mem_timeout, 1'b0);
        chk("cnt_stall_a_8", bus_a.stall_cycles, CNT_ON ? 8 : 0);
        chk("cnt_bubble_a_10", bus_a.bubble_cycles, CNT_ON ? 10 : 0);
        chk("cnt_stall_b_sat", bus_b.stall_cycles, CNT_ON ? 7 : 0);
        chk("cnt_bubble_b_sat", bus_b.bubble_cycles, CNT_ON ? 7 : 0);

        // ---- memory timeout (MAX_WAIT=4), wait held for 6 cycles ----
        bus_a.mem_req = 1'b1;
        #1 chk("tmo_c1", vec_a, V_MW);
        repeat (3) tick();
        chk("tmo_c4_not_halted", bus_a.halted, 1'b0);
        chk("tmo_c4_not_timeout", bus_a.mem_timeout, 1'b0);
        tick();
        chk("tmo_halted", bus_a.halted, 1'b1);
        chk("tmo_timeout", bus_a.mem_timeout, 1'b1);
        chk("tmo_outputs", vec_a, V_HALT);
        repeat (2) tick();
        bus_a.mem_req = 1'b0;
        #1 chk("tmo_halt_sticky", bus_a.halted, 1'b1);
        chk("tmo_timeout_sticky", bus_a.mem_timeout, 1'b1);
        chk("tmo_halt_outputs", vec_a, V_HALT);
        chk("cnt_stall_a_frozen", bus_a.stall_cycles, CNT_ON ? 12 : 0);
        chk("cnt_bubble_a_frozen", bus_a.bubble_cycles, CNT_ON ? 14 : 0);

        // ---- asynchronous reset in HALT ----
        #2 rst_n = 1'b0;
        #1 chk("rst_halt_outputs", vec_a, V_NONE);
        chk("rst_halt_halted", bus_a.halted, 1'b0);
        chk("rst_halt_timeout", bus_a.mem_timeout, 1'b0);
        chk("rst_halt_stall_cnt", bus_a.stall_cycles, 0);
        chk("rst_halt_bubble_cnt", bus_a.bubble_cycles, 0);
        tick();
        rst_n = 1'b1;

        // ---- write-back exception ----
        set_idle();
        bus_a.W_stat = 4'h4;
        #1 chk("w_exception", vec_a, V_WX);
        chk("w_exception_not_yet_halted", bus_a.halted, 1'b0);
        tick();
        bus_a.W_stat = 4'h1;
        #1 chk("w_exception_halted", bus_a.halted, 1'b1);
        chk("w_exception_halt_outputs", vec_a, V_HALT);

        // ---- write-back exception during a memory wait ----
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        set_idle();
        bus_a.mem_req = 1'b1;
        bus_a.W_stat  = 4'h4;
        #1 chk("wx_during_mw", vec_a, V_MW);
        tick();
        set_idle();
        #1 chk("wx_during_mw_halted", bus_a.halted, 1'b1);
        chk("wx_during_mw_no_timeout", bus_a.mem_timeout, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
